// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: fetch FSM states, word widths,
// default ROM geometry and the opcode that stops instruction fetch.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam int                 ROM_DEPTH   = 256;
  localparam logic [INSTR_W-1:0] HALT_OPCODE = 16'hFFFF;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

endpackage : cpu_pkg

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register driving a combinational ROM, a one-entry
// output stage toward decode, redirect handling, PC wrap and HALT detection.
module fetch_unit #(
  parameter int                          ROM_DEPTH   = cpu_pkg::ROM_DEPTH,
  parameter logic [cpu_pkg::INSTR_W-1:0] HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [cpu_pkg::ADDR_W-1:0]    pc_o,
  input  logic [cpu_pkg::INSTR_W-1:0]   instr_i,
  input  logic                          redirect_valid_i,
  input  logic [cpu_pkg::ADDR_W-1:0]    redirect_pc_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [cpu_pkg::INSTR_W-1:0]   out_instr_o,
  output logic [cpu_pkg::ADDR_W-1:0]    out_pc_o,
  output logic                          halted_o,
  output logic [15:0]                   fetch_count_o
);

  import cpu_pkg::fetch_state_t;
  import cpu_pkg::FETCH;
  import cpu_pkg::HALT;

  localparam int AW = cpu_pkg::ADDR_W;
  localparam int IW = cpu_pkg::INSTR_W;

  localparam int            PC_BITS = $clog2(ROM_DEPTH);
  localparam logic [AW-1:0] PC_MASK = AW'((32'd1 << PC_BITS) - 32'd1);
  localparam logic [AW-1:0] PC_LAST = AW'(ROM_DEPTH - 1);

  fetch_state_t  state_q;
  logic [AW-1:0] pc_q;
  logic          out_valid_q;
  logic [IW-1:0] out_instr_q;
  logic [AW-1:0] out_pc_q;
  logic [15:0]   count_q;

  logic          advance;
  logic          handshake;
  logic          capture_halt;
  logic [AW-1:0] pc_step_d;
  logic [AW-1:0] redirect_pc_d;
  logic [15:0]   count_d;

  // The output stage may refill in the same cycle it is drained.
  assign handshake     = out_valid_q && out_ready_i;
  assign advance       = (state_q == FETCH) && (!out_valid_q || out_ready_i);
  assign capture_halt  = (instr_i == HALT_OPCODE);
  assign pc_step_d     = (pc_q == PC_LAST) ? '0 : pc_q + AW'(1);
  assign redirect_pc_d = redirect_pc_i & PC_MASK;
  assign count_d       = count_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      count_q     <= '0;
    end else begin
      if (handshake) begin
        count_q <= count_d;
      end

      // Redirect overrides everything, including a HALT word on instr_i.
      if (redirect_valid_i) begin
        pc_q        <= redirect_pc_d;
        out_valid_q <= 1'b0;
        state_q     <= FETCH;
      end else if (advance) begin
        out_instr_q <= instr_i;
        out_pc_q    <= pc_q;
        out_valid_q <= 1'b1;
        if (capture_halt) begin
          state_q <= HALT;
        end else begin
          pc_q <= pc_step_d;
        end
      end else if (handshake) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign pc_o          = pc_q;
  assign out_valid_o   = out_valid_q;
  assign out_instr_o   = out_instr_q;
  assign out_pc_o      = out_pc_q;
  assign halted_o      = (state_q == HALT);
  assign fetch_count_o = count_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural ROM, scoreboard of expected deliveries,
// directed phases for streaming, stall, redirect, wrap, halt and reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_o;
  logic [15:0] instr_i;
  logic        redirect_valid_i;
  logic [15:0] redirect_pc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_instr_o;
  logic [15:0] out_pc_o;
  logic        halted_o;
  logic [15:0] fetch_count_o;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } sb_t;

  sb_t         sb_q[$];
  logic [15:0] rom [256];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign instr_i = (pc_o < 16'd256) ? rom[pc_o[7:0]] : 16'h0000;

  fetch_unit #(.ROM_DEPTH(256), .HALT_OPCODE(16'hFFFF)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_o             (pc_o),
    .instr_i          (instr_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_instr_o      (out_instr_o),
    .out_pc_o         (out_pc_o),
    .halted_o         (halted_o),
    .fetch_count_o    (fetch_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] pc);
    sb_t e;
    e.pc    = pc;
    e.instr = rom[pc[7:0]];
    sb_q.push_back(e);
  endtask

  // A handshake is due at the next rising edge whenever valid and ready are
  // both high mid-cycle; compare it against the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      sb_t e;
      chk("sb_pending", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        $display("handshake pc=%04h instr=%04h", out_pc_o, out_instr_o);
        chk("hs_pc", out_pc_o, e.pc);
        chk("hs_instr", out_instr_o, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 256; i++) rom[i] = 16'hA000 ^ 16'(i * 257);
    rst_n            = 1'b0;
    out_ready_i      = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 16'h0000;

    // Reset values
    tick(); tick();
    chk("rst_pc", pc_o, 16'h0);
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_instr", out_instr_o, 16'h0);
    chk("rst_out_pc", out_pc_o, 16'h0);
    chk("rst_halted", halted_o, 1'b0);
    chk("rst_count", fetch_count_o, 16'h0);

    // Streaming 0..5 with ready held high
    for (int a = 0; a < 6; a++) push(16'(a));
    rst_n       = 1'b1;
    out_ready_i = 1'b1;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cyc++;
      if (fetch_count_o == 16'd6) break;
    end
    chk("stream_cycles", cyc, 7);
    chk("stream_count", fetch_count_o, 16'd6);
    out_ready_i = 1'b0;

    // Stall: output and PC hold
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_out_pc", out_pc_o, 16'd6);
      chk("stall_instr", out_instr_o, rom[6]);
      chk("stall_pc", pc_o, 16'd7);
      chk("stall_valid", out_valid_o, 1'b1);
    end
    push(16'd6);
    push(16'd7);
    out_ready_i = 1'b1;
    tick();
    chk("resume_out_pc", out_pc_o, 16'd7);
    chk("resume_count", fetch_count_o, 16'd7);

    // Redirect with upper bits beyond ROM range
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 16'h0140;
    tick();
    redirect_valid_i = 1'b0;
    chk("redir_pc", pc_o, 16'h0040);
    chk("redir_bubble", out_valid_o, 1'b0);
    chk("redir_count", fetch_count_o, 16'd8);
    push(16'h0040);
    tick();
    chk("redir_valid", out_valid_o, 1'b1);
    chk("redir_out_pc", out_pc_o, 16'h0040);
    chk("redir_instr", out_instr_o, rom[8'h40]);

    // Wrap 254, 255, 0, 1 without bubbles
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 16'h00FE;
    tick();
    redirect_valid_i = 1'b0;
    chk("wrap_pc", pc_o, 16'h00FE);
    push(16'd254);
    push(16'd255);
    push(16'd0);
    tick(); chk("wrap_a", out_pc_o, 16'd254);
    tick(); chk("wrap_b", out_pc_o, 16'd255);
    tick(); chk("wrap_c", out_pc_o, 16'd0);
    chk("wrap_c_valid", out_valid_o, 1'b1);
    tick(); chk("wrap_d", out_pc_o, 16'd1);

    // HALT word at address 3
    rom[3] = 16'hFFFF;
    push(16'd1);
    push(16'd2);
    push(16'd3);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (halted_o) break;
    end
    chk("halt_seen", halted_o, 1'b1);
    chk("halt_out_pc", out_pc_o, 16'd3);
    chk("halt_instr", out_instr_o, 16'hFFFF);
    chk("halt_pc", pc_o, 16'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_hold_pc", pc_o, 16'd3);
      chk("halt_drained", out_valid_o, 1'b0);
      chk("halt_stays", halted_o, 1'b1);
    end
    chk("halt_count", fetch_count_o, 16'd15);

    // Redirect out of HALT
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 16'h0000;
    tick();
    redirect_valid_i = 1'b0;
    rom[3] = 16'hA000 ^ 16'(3 * 257);
    chk("unhalt", halted_o, 1'b0);
    chk("unhalt_pc", pc_o, 16'd0);
    push(16'd0);
    push(16'd1);
    tick(); chk("resume0", out_pc_o, 16'd0);
    tick(); chk("resume1", out_pc_o, 16'd1);
    tick(); chk("resume2", out_pc_o, 16'd2);
    out_ready_i = 1'b0;
    tick();
    chk("pre_rst_valid", out_valid_o, 1'b1);
    chk("pre_rst_count", fetch_count_o, 16'd17);

    // Asynchronous reset mid-stall
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid_o, 1'b0);
    chk("arst_instr", out_instr_o, 16'h0);
    chk("arst_out_pc", out_pc_o, 16'h0);
    chk("arst_pc", pc_o, 16'h0);
    chk("arst_count", fetch_count_o, 16'h0);
    chk("arst_sb_empty", sb_q.size(), 0);
    tick();
    rst_n       = 1'b1;
    out_ready_i = 1'b1;
    push(16'd0);
    push(16'd1);
    tick();
    chk("post_rst_out_pc", out_pc_o, 16'd0);
    chk("post_rst_valid", out_valid_o, 1'b1);
    chk("post_rst_instr", out_instr_o, rom[0]);
    tick(); chk("post_rst_a", out_pc_o, 16'd1);
    tick(); chk("post_rst_b", out_pc_o, 16'd2);
    out_ready_i = 1'b0;
    tick();
    chk("post_rst_count", fetch_count_o, 16'd2);
    chk("sb_drain", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fetch_unit
